// File: rtl/mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mul_ctrl
// Description : EX-stage sequencer for an unsigned multi-cycle multiplier;
//               handles RV64M sign correction, half select and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [2:0]           in_funct3,
    input  logic                 in_word,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic                 out_illegal,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_result,
    input  logic                 mul_ready
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ISSUE = 3'd1;
    localparam logic [2:0] c_WAIT  = 3'd2;
    localparam logic [2:0] c_DONE  = 3'd3;
    localparam logic [2:0] c_DRAIN = 3'd4;

    logic [2:0]         r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_result;
    logic               r_out_illegal;
    logic               r_mul_start;
    logic [WIDTH-1:0]   r_mul_a;
    logic [WIDTH-1:0]   r_mul_b;
    logic               r_neg;
    logic               r_hi;
    logic               r_word;

    // Request decode: MULH treats both operands as signed, MULHSU only rs1.
    logic               w_signed_a;
    logic               w_signed_b;
    logic               w_sign_a;
    logic               w_sign_b;
    logic               w_illegal;
    logic               w_zero;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;

    assign w_signed_a = (in_funct3 == 3'b001) || (in_funct3 == 3'b010);
    assign w_signed_b = (in_funct3 == 3'b001);
    assign w_sign_a   = w_signed_a & in_a[WIDTH-1];
    assign w_sign_b   = w_signed_b & in_b[WIDTH-1];
    assign w_mag_a    = w_sign_a ? -in_a : in_a;
    assign w_mag_b    = w_sign_b ? -in_b : in_b;
    assign w_illegal  = in_funct3[2] | (in_word & (in_funct3 != 3'b000));
    assign w_zero     = (in_a == '0) || (in_b == '0);

    // Negating the full-width product wraps naturally at 2*WIDTH bits.
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_sel;

    assign w_prod = r_neg ? -mul_result : mul_result;

    always_comb begin
        w_sel = w_prod[WIDTH-1:0];
        if (r_hi) begin
            w_sel = w_prod[2*WIDTH-1:WIDTH];
        end else if (r_word) begin
            w_sel = {{(WIDTH-32){w_prod[31]}}, w_prod[31:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_illegal <= 1'b0;
            r_mul_start   <= 1'b0;
            r_mul_a       <= '0;
            r_mul_b       <= '0;
            r_neg         <= 1'b0;
            r_hi          <= 1'b0;
            r_word        <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid && !flush) begin
                        r_in_ready <= 1'b0;
                        r_neg      <= w_sign_a ^ w_sign_b;
                        r_hi       <= (in_funct3[1:0] != 2'b00);
                        r_word     <= in_word;
                        r_mul_a    <= w_mag_a;
                        r_mul_b    <= w_mag_b;
                        if (w_illegal || w_zero) begin
                            r_state       <= c_DONE;
                            r_out_valid   <= 1'b1;
                            r_out_result  <= '0;
                            r_out_illegal <= w_illegal;
                        end else begin
                            r_state     <= c_ISSUE;
                            r_mul_start <= 1'b1;
                        end
                    end
                end
                c_ISSUE: begin
                    r_mul_start <= 1'b0;
                    if (flush) begin
                        r_state    <= c_IDLE;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_state <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    // A flush coinciding with the product has nothing left to drain.
                    if (mul_ready && flush) begin
                        r_state    <= c_IDLE;
                        r_in_ready <= 1'b1;
                    end else if (mul_ready) begin
                        r_state       <= c_DONE;
                        r_out_valid   <= 1'b1;
                        r_out_result  <= w_sel;
                        r_out_illegal <= 1'b0;
                    end else if (flush) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_DONE: begin
                    if (flush || out_ready) begin
                        r_state     <= c_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                c_DRAIN: begin
                    if (mul_ready) begin
                        r_state    <= c_IDLE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= c_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_mul_start <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_result  = r_out_result;
    assign out_illegal = r_out_illegal;
    assign mul_start   = r_mul_start;
    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;

endmodule
`default_nettype wire

// File: tb/tb_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_ctrl
// Description : Scoreboard bench for mul_ctrl with a variable-latency
//               multiplier model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_ctrl;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [63:0]   in_a = '0;
    logic [63:0]   in_b = '0;
    logic [2:0]    in_funct3 = '0;
    logic          in_word = 1'b0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [63:0]   out_result;
    logic          out_illegal;
    logic          mul_start;
    logic [63:0]   mul_a;
    logic [63:0]   mul_b;
    logic [127:0]  mul_result;
    logic          mul_ready;

    mul_ctrl #(.WIDTH(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_funct3  (in_funct3),
        .in_word    (in_word),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_illegal(out_illegal),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .mul_ready  (mul_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] res;
        logic        ill;
    } exp_t;

    exp_t  sb_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    starts = 0;
    int    lat = 8;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: sign-extend to 128 bits and multiply modulo 2^128.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic [2:0] f3, input logic w);
        logic [127:0] ea;
        logic [127:0] eb;
        logic [127:0] p;
        exp_t e;
        e.ill = f3[2] || (w && (f3 != 3'b000));
        e.res = '0;
        if (!e.ill) begin
            ea = (f3 == 3'b001 || f3 == 3'b010) ? {{64{a[63]}}, a} : {64'b0, a};
            eb = (f3 == 3'b001) ? {{64{b[63]}}, b} : {64'b0, b};
            p  = ea * eb;
            if (w)                 e.res = {{32{p[31]}}, p[31:0]};
            else if (f3 == 3'b000) e.res = p[63:0];
            else                   e.res = p[127:64];
        end
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mul_start) starts <= starts + 1;

    // Multiplier model: ready pulse 'lat' cycles after the start cycle.
    logic          mdl_rdy = 1'b0;
    logic          stray_rdy = 1'b0;
    logic [127:0]  mdl_res = '0;
    logic [63:0]   cap_a = '0;
    logic [63:0]   cap_b = '0;
    int            mcnt = 0;

    assign mul_ready  = mdl_rdy | stray_rdy;
    assign mul_result = mdl_res;

    always @(posedge clk) begin
        mdl_rdy <= 1'b0;
        if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) begin
                mdl_rdy <= 1'b1;
                mdl_res <= {64'b0, cap_a} * {64'b0, cap_b};
            end
        end
        if (mul_start) begin
            cap_a <= mul_a;
            cap_b <= mul_b;
            if (lat <= 1) begin
                mdl_rdy <= 1'b1;
                mdl_res <= {64'b0, mul_a} * {64'b0, mul_b};
                mcnt    <= 0;
            end else begin
                mcnt <= lat - 1;
            end
        end
    end

    // Scoreboard consumer.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_output", 128'(1), 128'(0));
            end else begin
                e = sb_q.pop_front();
                chk("result", 128'(out_result), 128'(e.res));
                chk("illegal", 128'(out_illegal), 128'(e.ill));
            end
        end
    end

    // Returns acc such that cyc - acc, read on a negedge, is the spec cycle index.
    task automatic send(input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] f3, input logic w, output int acc);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 128'(0), 128'(1));
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_funct3 = f3;
        in_word   = w;
        @(posedge clk); #1;
        acc      = cyc - 1;
        in_valid = 1'b0;
        sb_q.push_back(model(a, b, f3, w));
    endtask

    task automatic wait_valid(input int acc, input int exp_lat, input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 128'(cyc - acc), 128'(exp_lat));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drain", 128'(sb_q.size()), 128'(0));
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'h0;
            1:       return 64'h8000_0000_0000_0000;
            2:       return 64'hFFFF_FFFF_FFFF_FFFF;
            3:       return {32'b0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int acc;
        int s0;
        int bad;
        int exp_starts;
        exp_t e;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [2:0]  rf;
        logic        rw;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_result", 128'(out_result), 128'(0));
        chk("rst_out_illegal", 128'(out_illegal), 128'(0));
        chk("rst_mul_start", 128'(mul_start), 128'(0));
        chk("rst_mul_ab", {mul_a, mul_b}, 128'(0));

        // MUL 7 * -3: low half, no operand conversion.
        s0 = starts;
        send(64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 3'b000, 1'b0, acc);
        @(negedge clk);
        chk("mul_issue_start", 128'(mul_start), 128'(1));
        chk("mul_issue_a", 128'(mul_a), 128'(7));
        chk("mul_issue_b", 128'(mul_b), 128'(64'hFFFF_FFFF_FFFF_FFFD));
        wait_valid(acc, 10, "mul_latency_L8");
        chk("mul_exp_value", 128'(model(64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 3'b000, 1'b0).res),
            128'(64'hFFFF_FFFF_FFFF_FFEB));
        wait_idle();
        chk("mul_one_start", 128'(starts - s0), 128'(1));

        // MULH most-negative squared: magnitude 2^63 on both ports.
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b001, 1'b0, acc);
        @(negedge clk);
        chk("mulh_issue_ab", {mul_a, mul_b},
            {64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000});
        wait_idle();

        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011, 1'b0, acc);
        wait_idle();
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 3'b010, 1'b0, acc);
        @(negedge clk);
        chk("mulhsu_issue_a", 128'(mul_a), 128'(1));
        wait_idle();
        send(64'h0000_0000_7FFF_FFFF, 64'd2, 3'b000, 1'b1, acc);
        wait_idle();

        // Zero fast path and illegal encodings: one-cycle response, no start.
        s0 = starts;
        send(64'd0, 64'd55, 3'b001, 1'b0, acc);
        wait_valid(acc, 1, "zero_latency");
        wait_idle();
        send(64'd3, 64'd4, 3'b100, 1'b0, acc);
        wait_valid(acc, 1, "illegal_latency");
        wait_idle();
        send(64'd3, 64'd4, 3'b001, 1'b1, acc);
        wait_idle();
        repeat (2) @(negedge clk);
        chk("fastpath_no_start", 128'(starts - s0), 128'(0));

        // Backpressure: result held and in_ready low while out_ready is low.
        out_ready = 1'b0;
        s0 = starts;
        e = model(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 3'b011, 1'b0);
        send(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 3'b011, 1'b0, acc);
        wait_valid(acc, 10, "bp_latency");
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!out_valid || out_result !== e.res || in_ready) bad++;
        end
        chk("bp_hold_stable", 128'(bad), 128'(0));
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_no_turnaround", 128'(in_ready), 128'(0));
        @(negedge clk);
        chk("bp_in_ready_back", 128'(in_ready), 128'(1));
        chk("bp_valid_dropped", 128'(out_valid), 128'(0));
        chk("bp_one_start", 128'(starts - s0), 128'(1));

        // Flush while waiting: drain the product, never present it.
        send(64'd9, 64'd11, 3'b000, 1'b0, acc);
        void'(sb_q.pop_back());
        repeat (2) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        bad = 0;
        s0 = 0;
        while (!mul_ready && s0 < 30) begin
            @(negedge clk);
            if (in_ready || out_valid) bad++;
            s0++;
        end
        chk("drain_hold", 128'(bad), 128'(0));
        chk("drain_saw_ready", 128'(mul_ready), 128'(1));
        @(negedge clk);
        chk("drain_in_ready", 128'(in_ready), 128'(1));
        repeat (3) @(negedge clk);
        chk("drain_no_valid", 128'(out_valid), 128'(0));

        // Reset in WAIT; the late product and a stray pulse must be ignored.
        send(64'd21, 64'd13, 3'b000, 1'b0, acc);
        void'(sb_q.pop_back());
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("wrst_outputs", {out_result, 61'b0, out_valid, out_illegal, mul_start},
            128'(0));
        chk("wrst_mul_ab", {mul_a, mul_b}, 128'(0));
        chk("wrst_in_ready", 128'(in_ready), 128'(1));
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid || !in_ready) bad++;
        end
        @(posedge clk); #1 stray_rdy = 1'b1;
        @(posedge clk); #1 stray_rdy = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (out_valid || !in_ready) bad++;
        end
        chk("wrst_stray_ignored", 128'(bad), 128'(0));

        // Flush in IDLE beats in_valid.
        s0 = starts;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = 64'd3; in_b = 64'd5; in_funct3 = 3'b000; in_word = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_flush_ignored", {126'b0, out_valid, in_ready}, 128'(1));
        chk("idle_flush_no_start", 128'(starts - s0), 128'(0));

        // Flush in DONE drops the pending result.
        out_ready = 1'b0;
        send(64'd0, 64'd0, 3'b000, 1'b0, acc);
        void'(sb_q.pop_back());
        @(negedge clk);
        chk("done_valid", 128'(out_valid), 128'(1));
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("done_flush", {126'b0, out_valid, in_ready}, 128'(1));
        out_ready = 1'b1;

        // Randomised mix against the reference model.
        exp_starts = 0;
        s0 = starts;
        for (int i = 0; i < 30; i++) begin
            ra = pick();
            rb = pick();
            rf = 3'($urandom_range(0, 3));
            rw = ($urandom_range(0, 3) == 0);
            if (rw && $urandom_range(0, 2) != 0) rf = 3'b000;
            if ($urandom_range(0, 9) == 0) rf = 3'($urandom_range(4, 7));
            lat = $urandom_range(1, 6);
            if (!model(ra, rb, rf, rw).ill && ra != 0 && rb != 0) exp_starts++;
            send(ra, rb, rf, rw, acc);
        end
        wait_idle();
        repeat (2) @(negedge clk);
        chk("rand_starts", 128'(starts - s0), 128'(exp_starts));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
